// File: rtl/fir_pkg.sv
// Shared types and constants for the 15-tap FIR accumulator.
// COEF holds the bring-up ramp, indexed by sample age; production values replace it.
package fir_pkg;

    localparam int DW    = 8;
    localparam int CW    = 8;
    localparam int AW    = DW + CW + 4;
    localparam int DEPTH = 15;
    localparam int NSTEP = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_DONE
    } state_t;

    localparam logic signed [CW-1:0] COEF [0:DEPTH-1] = '{
        8'sd1,  8'sd2,  8'sd3,  8'sd4,  8'sd5,
        8'sd6,  8'sd7,  8'sd8,  8'sd9,  8'sd10,
        8'sd11, 8'sd12, 8'sd13, 8'sd14, 8'sd15
    };

    // Age of the sample at addr relative to newest, modulo the buffer depth.
    function automatic logic [3:0] age_of(input logic [3:0] newest, input logic [3:0] addr);
        logic [4:0] diff;
        diff = {1'b0, newest} + 5'd15 - {1'b0, addr};
        if (diff >= 5'd15) begin
            diff = diff - 5'd15;
        end
        return diff[3:0];
    endfunction

endpackage

// File: rtl/sample_regfile.sv
// 15-entry sample store: one synchronous write port, three asynchronous read ports.
// Address 15 is outside the buffer; writes there are ignored and reads return 0.
module sample_regfile #(
    parameter int DW    = 8,
    parameter int DEPTH = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_we,
    input  logic [3:0]          i_waddr,
    input  logic [DW-1:0]       i_wdata,
    input  logic [2:0][3:0]     i_raddr,
    output logic [2:0][DW-1:0]  o_rdata
);

    localparam logic [3:0] LAST_ADDR = 4'(DEPTH - 1);

    logic [DW-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr <= LAST_ADDR)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_rd
        assign o_rdata[gi] = (i_raddr[gi] > LAST_ADDR) ? '0 : r_mem[i_raddr[gi]];
    end

endmodule

// File: rtl/fir_tap_accumulator.sv
// 15-tap FIR over a circular sample buffer: three taps per cycle for five cycles,
// coefficient chosen by sample age, result presented with a one-cycle Valid.
module fir_tap_accumulator #(
    parameter int DW = fir_pkg::DW,
    parameter int CW = fir_pkg::CW,
    parameter int AW = fir_pkg::AW
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 StartIn,
    input  logic signed [DW-1:0] DataIn,
    output logic                 Ready,
    output logic                 Start,
    input  logic [3:0]           WriteReg,
    output logic                 ReadEn,
    input  logic [3:0]           ReadReg1,
    input  logic [3:0]           ReadReg2,
    input  logic [3:0]           ReadReg3,
    output logic signed [AW-1:0] Result,
    output logic                 Valid
);

    import fir_pkg::state_t;
    import fir_pkg::S_IDLE;
    import fir_pkg::S_ACC;
    import fir_pkg::S_DONE;
    import fir_pkg::COEF;
    import fir_pkg::DEPTH;
    import fir_pkg::NSTEP;
    import fir_pkg::age_of;

    localparam logic [2:0] LAST_STEP = 3'(NSTEP - 1);
    localparam int         PW        = DW + CW;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_step;
    logic [3:0]            r_newest;
    logic signed [AW-1:0]  r_acc;
    logic signed [AW-1:0]  r_result;
    logic                  w_start;

    logic [2:0][3:0]       w_raddr;
    logic [2:0][DW-1:0]    w_rdata;
    logic [3:0]            w_age      [3];
    logic signed [PW-1:0]  w_prod     [3];
    logic signed [AW-1:0]  w_prod_ext [3];
    logic signed [AW-1:0]  w_mac;

    assign w_start = StartIn & Ready;
    assign Start   = w_start;
    assign Result  = r_result;
    assign w_raddr = {ReadReg3, ReadReg2, ReadReg1};

    sample_regfile #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_start),
        .i_waddr (WriteReg),
        .i_wdata (DataIn),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Operands are widened to the full product width before multiplying.
    for (genvar gi = 0; gi < 3; gi++) begin : g_lane
        logic signed [PW-1:0] w_a;
        logic signed [PW-1:0] w_b;
        logic signed [CW-1:0] w_coef;

        assign w_age[gi]      = age_of(r_newest, w_raddr[gi]);
        assign w_coef         = COEF[w_age[gi]];
        assign w_a            = {{CW{w_rdata[gi][DW-1]}}, w_rdata[gi]};
        assign w_b            = {{DW{w_coef[CW-1]}}, w_coef};
        assign w_prod[gi]     = w_a * w_b;
        assign w_prod_ext[gi] = {{(AW-PW){w_prod[gi][PW-1]}}, w_prod[gi]};
    end

    assign w_mac = r_acc + w_prod_ext[0] + w_prod_ext[1] + w_prod_ext[2];

    always_comb begin
        w_state_next = r_state;
        Ready        = 1'b1;
        ReadEn       = 1'b0;
        Valid        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (StartIn) w_state_next = S_ACC;
            end
            S_ACC: begin
                Ready  = 1'b0;
                ReadEn = 1'b1;
                if (r_step == LAST_STEP) w_state_next = S_DONE;
            end
            S_DONE: begin
                Valid        = 1'b1;
                w_state_next = StartIn ? S_ACC : S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_step   <= '0;
            r_newest <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_ACC) begin
                r_acc  <= w_mac;
                r_step <= r_step + 3'd1;
                if (r_step == LAST_STEP) r_result <= w_mac;
            end else if (w_start) begin
                r_newest <= WriteReg;
                r_acc    <= '0;
                r_step   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Randomized and directed bench for fir_tap_accumulator with an age-based FIR model
// and a queue-driven monitor; includes a model of the upstream address counter.
module tb_fir_tap_accumulator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               StartIn = 1'b0;
    logic signed [7:0]  DataIn = '0;
    logic               Ready;
    logic               Start;
    logic [3:0]         WriteReg;
    logic               ReadEn;
    logic [3:0]         ReadReg1, ReadReg2, ReadReg3;
    logic signed [19:0] Result;
    logic               Valid;

    typedef struct {
        int res;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   hist[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   next_ok  = 0;
    int   last_res = 0;
    int   ren_cnt  = 0;
    exp_t mon_e;

    fir_tap_accumulator dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .StartIn  (StartIn),
        .DataIn   (DataIn),
        .Ready    (Ready),
        .Start    (Start),
        .WriteReg (WriteReg),
        .ReadEn   (ReadEn),
        .ReadReg1 (ReadReg1),
        .ReadReg2 (ReadReg2),
        .ReadReg3 (ReadReg3),
        .Result   (Result),
        .Valid    (Valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream address counter: write pointer steps per accepted sample,
    // read pointers step by three per ReadEn.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WriteReg <= 4'd0;
            ReadReg1 <= 4'd14;
            ReadReg2 <= 4'd0;
            ReadReg3 <= 4'd1;
        end else begin
            if (Start) WriteReg <= 4'((int'(WriteReg) + 1) % 15);
            if (ReadEn) begin
                ReadReg1 <= 4'((int'(ReadReg1) + 3) % 15);
                ReadReg2 <= 4'((int'(ReadReg2) + 3) % 15);
                ReadReg3 <= 4'((int'(ReadReg3) + 3) % 15);
            end
        end
    end

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    // FIR output = sum over ages k of sample(age k) * (k+1), newest has age 0.
    function automatic int fir_model();
        int s = 0;
        foreach (hist[k]) s += hist[k] * (k + 1);
        return s;
    endfunction

    task automatic cycle_drive(input bit s, input int d, output bit acc);
        bit exp_rdy;
        @(posedge clk);
        #1;
        StartIn = s;
        DataIn  = 8'(d);
        @(negedge clk);
        exp_rdy = (cyc >= next_ok);
        chk("ready", int'(Ready), int'(exp_rdy));
        chk("start", int'(Start), int'(s && exp_rdy));
        acc = s && exp_rdy;
        if (acc) begin
            hist.push_front(d);
            if (hist.size() > 15) void'(hist.pop_back());
            sb.push_back('{fir_model(), cyc + 6});
            $display("accept cyc=%0d data=%0d expect=%0d", cyc, d, fir_model());
            next_ok = cyc + 6;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle_drive(1'b0, 0, a);
    endtask

    task automatic send(input int d);
        bit a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) cycle_drive(1'b1, d, a);
        chk("accept_timeout", int'(a), 1);
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready",  int'(Ready),  1);
        chk("rst_valid",  int'(Valid),  0);
        chk("rst_result", int'(Result), 0);
        chk("rst_readen", int'(ReadEn), 0);
        chk("rst_start",  int'(Start),  0);
    endtask

    // Monitor: pops one expectation per Valid pulse.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_res = 0;
            ren_cnt  = 0;
        end else begin
            if (ReadEn) ren_cnt++;
            if (Valid) begin
                if (sb.size() == 0) begin
                    chk("valid_unexpected", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    $display("valid cyc=%0d result=%0d expect=%0d", cyc, int'(Result), mon_e.res);
                    chk("result",       int'(Result), mon_e.res);
                    chk("valid_cycle",  cyc,          mon_e.cyc);
                    chk("readen_count", ren_cnt,      5);
                    last_res = mon_e.res;
                end
                ren_cnt = 0;
            end else begin
                chk("result_hold", int'(Result), last_res);
            end
        end
    end

    initial begin
        bit a;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Impulse: 1, 2, 3 expected.
        send(1); send(0); send(0);
        idle(3);

        // Full-scale windows, issued back to back (accepted in DONE).
        for (int i = 0; i < 15; i++) send(127);
        for (int i = 0; i < 15; i++) send(-128);
        // Wrap: 1..16.
        for (int i = 1; i <= 16; i++) send(i);
        idle(8);

        // Busy drop at T+3.
        send(5);
        idle(2);
        cycle_drive(1'b1, 99, a);
        idle(8);

        // Reset at T+3 aborts the sum.
        send(42);
        idle(2);
        @(posedge clk);
        #1;
        rst_n   = 1'b0;
        StartIn = 1'b0;
        sb.delete();
        hist.delete();
        next_ok = 0;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);
        send(1);
        idle(8);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            cycle_drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128, a);
        end
        idle(1);

        for (int i = 0; i < 30 && sb.size() != 0; i++) @(posedge clk);
        chk("drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fir_tap_accumulator.md
# fir_tap_accumulator

Downstream consumer of the address counter. It holds a 15-entry circular buffer of signed 8-bit samples and writes each accepted sample at `WriteReg`. After every accepted sample it drives `ReadEn` for five cycles, reading three samples per cycle at `ReadReg1..3`. It computes a 15-tap weighted sum (FIR output) in which each coefficient is selected by sample age, and presents the result with a one-cycle `Valid` strobe.

## Interface
Parameters:
- `DW`, 8: sample width, signed.
- `CW`, 8: coefficient width, signed.
- `AW`, 20: accumulator/result width, equal to DW+CW+4.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `StartIn`  in  1  upstream sample strobe.
- `DataIn`  in  DW  sample accompanying StartIn.
- `Ready`  out  1  block can accept a sample this cycle.
- `Start`  out  1  = StartIn & Ready; combinational; drives the address counter's Start.
- `WriteReg`  in  4  write address from the counter, current (pre-advance) value.
- `ReadEn`  out  1  read-pointer advance for the counter.
- `ReadReg1`, `ReadReg2`, `ReadReg3`  in  4 each  read addresses from the counter.
- `Result`  out  AW  signed filter output, registered.
- `Valid`  out  1  Result updated; one-cycle pulse.

## Operation
- States: IDLE, ACC, DONE.
- IDLE: Ready=1. When Start=1, the block does three things:
  - writes DataIn into buf[WriteReg];
  - latches WriteReg as `newest`;
  - clears the accumulator, sets step=0, and goes to ACC.
- ACC: Ready=0 and ReadEn=1.
  - Each cycle, for lane L in 1..3, the block reads buf[ReadRegL] and computes age = (newest − ReadRegL) mod 15.
  - Each lane adds buf[ReadRegL] × COEF[age] to the accumulator.
  - step increments each cycle. At step=4 the block goes to DONE and Result is loaded with the final sum at that edge.
- DONE: Valid=1 and Ready=1 for one cycle. A Start in DONE is accepted exactly as in IDLE and goes straight to ACC. Otherwise the block returns to IDLE.
- Arithmetic:
  - products are full signed DW+CW bits;
  - the three lane products and the accumulator are sign-extended to AW;
  - no saturation is needed, since 15 × 2^15 fits in AW.
- A read address of 15 (illegal) returns data 0.
- Five ReadEn pulses return the counter's read pointers to their post-reset values 14/0/1. The block always issues exactly five.
- StartIn while Ready=0 is dropped: no write, Start=0, and the counter does not move.
- Reset values:
  - state IDLE, step 0, newest 0;
  - buf all 0, accumulator 0;
  - Result 0, Valid 0, ReadEn 0, Ready 1.
- Reset mid-ACC aborts the sum with no Valid. The counter shares rst_n, so its pointers realign.

## Timing
- Start accepted at cycle T. ACC occupies T+1..T+5. Valid=1 and the new Result appear in T+6.
- Next acceptable Start is T+6 (DONE), giving one sample per 6 cycles.
- ReadReg inputs are used combinationally in the cycle ReadEn=1; the counter advances them at that edge.
- Result holds its value between Valid pulses.

## Structure
- Package `fir_pkg`: DW, CW, AW, the state enum, and the `COEF[0:14]` ROM constant. Default COEF[k] = k+1 for bring-up; production values replace it.
- Sub-module `sample_regfile`: 15×DW, one synchronous write port and three asynchronous read ports; address 15 reads 0; resets to 0.
- The age computation and MAC stay in the top module.

## Test plan
- Reset: Ready=1, Valid=0, Result=0, ReadEn=0, Start=0.
- Impulse: one sample of 1 after reset gives Result=1 at T+6. A following sample of 0 gives Result=2. A third sample of 0 gives Result=3.
- Full-scale window:
  - 15 samples of 127 give final Result=15240;
  - 15 samples of −128 give −15360.
- Wrap: samples 1..16 give final Result=800, confirming that sample 1 was overwritten at address 0.
- Busy drop: StartIn at T+3 gives Start=0, no buffer change, and a Result equal to the no-drop case. A StartIn in DONE is accepted.
- Reset asserted at T+3: Valid never pulses for that sample; afterwards Ready=1 and the impulse test reproduces Result=1.
